// File: rtl/seg7_scan_ctrl_if.sv
// Bundle of the scanner's data/control inputs and display outputs.
// master: the side that drives the word and controls (CPU/debug bus).
// slave : the scanner itself.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4,
  parameter int DATA_W = 32
);
  localparam int NPAGES = DATA_W / (4 * DIGITS);
  localparam int PG_W   = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int DIG_W  = $clog2(DIGITS);

  logic [DATA_W-1:0] data_i;
  logic              hold_i;
  logic              load_i;
  logic [PG_W-1:0]   page_i;
  logic              blank_lz_i;
  logic [DIGITS-1:0] blink_i;
  logic [DIGITS-1:0] dp_i;
  logic [DIGITS-1:0] an_o;
  logic [7:0]        seg_o;
  logic [DIG_W-1:0]  digit_o;
  logic              frame_o;

  modport master (
    output data_i, hold_i, load_i, page_i, blank_lz_i, blink_i, dp_i,
    input  an_o, seg_o, digit_o, frame_o
  );

  modport slave (
    input  data_i, hold_i, load_i, page_i, blank_lz_i, blink_i, dp_i,
    output an_o, seg_o, digit_o, frame_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: snapshot hold, frame-aligned paging,
// leading-zero blanking, per-digit blink and an all-off guard at the start
// of every digit slot to suppress ghosting. an_o/seg_o are registered.
module seg7_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int DATA_W      = 32,
  parameter int PRESCALE    = 65536,
  parameter int GUARD       = 256,
  parameter int BLINK_SHIFT = 5,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_ctrl_if.slave    bus
);
  localparam int PAGE_BITS = 4 * DIGITS;
  localparam int NPAGES    = DATA_W / PAGE_BITS;
  localparam int PG_W      = (NPAGES > 1) ? $clog2(NPAGES) : 1;
  localparam int DIG_W     = $clog2(DIGITS);
  localparam int PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FC_W      = BLINK_SHIFT + 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [PRE_W-1:0]  GUARD_V  = PRE_W'(GUARD);
  localparam logic [DIG_W-1:0]  DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [PG_W-1:0]   PG_LAST  = PG_W'(NPAGES - 1);
  localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  // Hex digit to active-high gfedcba pattern.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  logic [PRE_W-1:0]  pre_cnt_q,   pre_cnt_d;
  logic [DIG_W-1:0]  digit_q,     digit_d;
  logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [PG_W-1:0]   page_q,      page_d;
  logic [DATA_W-1:0] snap_q,      snap_d;
  logic [DIGITS-1:0] an_q,        an_d;
  logic [7:0]        seg_q,       seg_d;
  logic              frame_q,     frame_d;

  logic                 slot_end_s;
  logic                 wrap_s;
  logic [PAGE_BITS-1:0] page_word_s;
  logic [3:0]           nib_s;
  logic                 lz_zero_s;
  logic                 blank_s;
  logic [DIGITS-1:0]    an_act_s;
  logic [7:0]           seg_act_s;

  // Slot/frame timing; the page is only switched on the frame wrap so a
  // frame never mixes two pages. Out-of-range pages clamp to the last one.
  always_comb begin
    slot_end_s  = (pre_cnt_q == PRE_LAST);
    wrap_s      = slot_end_s && (digit_q == DIG_LAST);
    pre_cnt_d   = slot_end_s ? '0 : pre_cnt_q + PRE_W'(1);
    digit_d     = digit_q;
    frame_cnt_d = frame_cnt_q;
    page_d      = page_q;
    frame_d     = wrap_s;
    if (slot_end_s) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
    end else begin
      digit_d = digit_q;
    end
    if (wrap_s) begin
      frame_cnt_d = frame_cnt_q + FC_W'(1);
      page_d      = (bus.page_i > PG_LAST) ? PG_LAST : bus.page_i;
    end else begin
      frame_cnt_d = frame_cnt_q;
      page_d      = page_q;
    end
  end

  // Snapshot follows data_i unless held; load_i refreshes a held snapshot.
  always_comb begin
    snap_d = snap_q;
    if (!bus.hold_i || bus.load_i) begin
      snap_d = bus.data_i;
    end else begin
      snap_d = snap_q;
    end
  end

  // Decode the current slot into anode/segment drive, applying guard,
  // leading-zero and blink blanking. Blanked slots drive everything off.
  always_comb begin
    page_word_s = snap_q[int'(page_q) * PAGE_BITS +: PAGE_BITS];
    nib_s       = page_word_s[int'(digit_q) * 4 +: 4];
    lz_zero_s   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if ((k >= int'(digit_q)) && (page_word_s[k*4 +: 4] != 4'h0)) begin
        lz_zero_s = 1'b0;
      end else begin
        lz_zero_s = lz_zero_s;
      end
    end
    blank_s = (pre_cnt_q < GUARD_V)
           || (bus.blank_lz_i && (digit_q != '0) && lz_zero_s)
           || (bus.blink_i[digit_q] && frame_cnt_q[BLINK_SHIFT]);
    an_act_s  = '0;
    seg_act_s = 8'h00;
    if (blank_s) begin
      an_act_s  = '0;
      seg_act_s = 8'h00;
    end else begin
      an_act_s  = DIGITS'(1) << digit_q;
      seg_act_s = {bus.dp_i[digit_q], hex7(nib_s)};
    end
    an_d  = (ACTIVE_LOW != 0) ? ~an_act_s  : an_act_s;
    seg_d = (ACTIVE_LOW != 0) ? ~seg_act_s : seg_act_s;
  end

  // State and output registers; reset forces slot 0, guard phase, display off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q   <= '0;
      digit_q     <= '0;
      frame_cnt_q <= '0;
      page_q      <= '0;
      snap_q      <= '0;
      an_q        <= AN_OFF;
      seg_q       <= SEG_OFF;
      frame_q     <= 1'b0;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      digit_q     <= digit_d;
      frame_cnt_q <= frame_cnt_d;
      page_q      <= page_d;
      snap_q      <= snap_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      frame_q     <= frame_d;
    end
  end

  assign bus.an_o    = an_q;
  assign bus.seg_o   = seg_q;
  assign bus.digit_o = digit_q;
  assign bus.frame_o = frame_q;
endmodule
